// File: rtl/median3x3_prefilter.sv
// Streaming 3x3 median prefilter: cleans the 8-bit camera stream and re-emits the video bus 4 clocks later.
// Optional build macro MEDIAN_BORDER_ZERO_EN: border pixels output 0 instead of the raw delayed pixel.
module median3x3_prefilter #(
  parameter int unsigned H_ACTIVE = 702,
  parameter int unsigned DATA_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              video_frame_valid_in,
  input  logic              video_line_valid_in,
  input  logic              video_data_valid_in,
  input  logic [DATA_W-1:0] video_data_in,
  output logic              video_frame_valid,
  output logic              video_line_valid,
  output logic              video_data_valid,
  output logic [DATA_W-1:0] video_data_out
);

  localparam int unsigned COL_W = 10;
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(H_ACTIVE);

  function automatic logic [DATA_W-1:0] min2(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [DATA_W-1:0] max2(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    return (a < b) ? b : a;
  endfunction

  function automatic logic [DATA_W-1:0] min3(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                             input logic [DATA_W-1:0] c);
    return min2(min2(a, b), c);
  endfunction

  function automatic logic [DATA_W-1:0] max3(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                             input logic [DATA_W-1:0] c);
    return max2(max2(a, b), c);
  endfunction

  function automatic logic [DATA_W-1:0] med3(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                             input logic [DATA_W-1:0] c);
    return max2(min2(a, b), min2(max2(a, b), c));
  endfunction

  logic [COL_W-1:0]  col;
  logic [1:0]        row;
  logic              line_prev;
  logic              resync;
  logic              col_ok;
  logic              lb_we;
  logic [COL_W-1:0]  lb_addr;
  logic [DATA_W-1:0] lb0 [H_ACTIVE];
  logic [DATA_W-1:0] lb1 [H_ACTIVE];
  logic [DATA_W-1:0] lb0_rd;
  logic [DATA_W-1:0] lb1_rd;

  logic [DATA_W-1:0] win [3][3];
  logic [DATA_W-1:0] rmin [3];
  logic [DATA_W-1:0] rmed [3];
  logic [DATA_W-1:0] rmax [3];
  logic [DATA_W-1:0] lo, mid, hi;
  logic [DATA_W-1:0] raw1, raw2, raw3;
  logic              border1, border2, border3;
  logic [DATA_W-1:0] border_pix;
  logic [3:0]        vpipe [3];

  assign col_ok  = col < COL_MAX;
  assign lb_addr = col_ok ? col : '0;
  assign lb_we   = video_data_valid_in && col_ok && !resync;
  assign lb0_rd  = lb0[lb_addr];
  assign lb1_rd  = lb1[lb_addr];

`ifdef MEDIAN_BORDER_ZERO_EN
  assign border_pix = '0;
`else
  assign border_pix = raw3;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col       <= '0;
      row       <= '0;
      line_prev <= 1'b0;
      resync    <= 1'b1;
    end else begin
      line_prev <= video_line_valid_in;
      if (!video_frame_valid_in)
        resync <= 1'b0;
      if (!video_line_valid_in)
        col <= '0;
      else if (video_data_valid_in && col_ok)
        col <= col + COL_W'(1);
      // a pixel coinciding with the line's falling edge still uses the old row
      if (!video_frame_valid_in)
        row <= '0;
      else if (line_prev && !video_line_valid_in && row != 2'd2)
        row <= row + 2'd1;
    end
  end

  // read-before-write: lb1 takes the previous lb0 contents of the same column
  always_ff @(posedge clk) begin
    if (lb_we) begin
      lb0[lb_addr] <= video_data_in;
      lb1[lb_addr] <= lb0_rd;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned r = 0; r < 3; r++) begin
        for (int unsigned c = 0; c < 3; c++)
          win[r][c] <= '0;
        rmin[r] <= '0;
        rmed[r] <= '0;
        rmax[r] <= '0;
        vpipe[r] <= '0;
      end
      lo                <= '0;
      mid               <= '0;
      hi                <= '0;
      raw1              <= '0;
      raw2              <= '0;
      raw3              <= '0;
      border1           <= 1'b0;
      border2           <= 1'b0;
      border3           <= 1'b0;
      video_frame_valid <= 1'b0;
      video_line_valid  <= 1'b0;
      video_data_valid  <= 1'b0;
      video_data_out    <= '0;
    end else begin
      if (video_data_valid_in) begin
        for (int unsigned r = 0; r < 3; r++) begin
          win[r][0] <= win[r][1];
          win[r][1] <= win[r][2];
        end
        win[0][2] <= lb1_rd;
        win[1][2] <= lb0_rd;
        win[2][2] <= video_data_in;
      end
      border1 <= (col < COL_W'(2)) || (row < 2'd2) || !col_ok;
      raw1    <= video_data_in;

      for (int unsigned r = 0; r < 3; r++) begin
        rmin[r] <= min3(win[r][0], win[r][1], win[r][2]);
        rmed[r] <= med3(win[r][0], win[r][1], win[r][2]);
        rmax[r] <= max3(win[r][0], win[r][1], win[r][2]);
      end
      border2 <= border1;
      raw2    <= raw1;

      lo      <= max3(rmin[0], rmin[1], rmin[2]);
      mid     <= med3(rmed[0], rmed[1], rmed[2]);
      hi      <= min3(rmax[0], rmax[1], rmax[2]);
      border3 <= border2;
      raw3    <= raw2;

      // bit 3 marks samples taken after resync cleared; gated samples emit all-zero
      vpipe[0] <= {1'b1, video_frame_valid_in, video_line_valid_in, video_data_valid_in} & {4{~resync}};
      vpipe[1] <= vpipe[0];
      vpipe[2] <= vpipe[1];

      video_frame_valid <= vpipe[2][2];
      video_line_valid  <= vpipe[2][1];
      video_data_valid  <= vpipe[2][0];
      if (!vpipe[2][3])
        video_data_out <= '0;
      else if (border3)
        video_data_out <= border_pix;
      else
        video_data_out <= med3(lo, mid, hi);
    end
  end

endmodule

// File: tb/tb_median3x3_prefilter.sv
// Bench for median3x3_prefilter: image-level model (true 9-sample median) checked every cycle, plus pinned literals.
module tb_median3x3_prefilter;

  localparam int W_MAX = 710;
  localparam int R_MAX = 20;
  localparam int HA    = 702;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       fv_in = 1'b0, lv_in = 1'b0, dv_in = 1'b0;
  logic [7:0] d_in = '0;
  logic       fv_o, lv_o, dv_o;
  logic [7:0] d_o;

  median3x3_prefilter #(.H_ACTIVE(HA), .DATA_W(8)) dut (
    .clk                  (clk),
    .reset                (reset),
    .video_frame_valid_in (fv_in),
    .video_line_valid_in  (lv_in),
    .video_data_valid_in  (dv_in),
    .video_data_in        (d_in),
    .video_frame_valid    (fv_o),
    .video_line_valid     (lv_o),
    .video_data_valid     (dv_o),
    .video_data_out       (d_o)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int img     [R_MAX][W_MAX];
  int out_img [R_MAX][W_MAX];
  int dv_seen = 0;

  bit m_resync = 1'b1;
  int m_x = 0, m_y = 0;
  bit m_lvp = 1'b0;
  int n_edges = 0;
  bit e_fv [8], e_lv [8], e_dv [8], e_chk [8];
  int e_d [8], e_x [8], e_y [8];

  function automatic int border_val(input int raw);
`ifdef MEDIAN_BORDER_ZERO_EN
    return 0;
`else
    return raw;
`endif
  endfunction

  function automatic int median9(input int y, input int x);
    int v [9];
    int n = 0;
    int t;
    for (int dy = 0; dy < 3; dy++)
      for (int dx = 0; dx < 3; dx++) begin
        v[n] = img[y - 2 + dy][x - 2 + dx];
        n++;
      end
    for (int i = 1; i < 9; i++)
      for (int j = i; j > 0 && v[j-1] > v[j]; j--) begin
        t = v[j]; v[j] = v[j-1]; v[j-1] = t;
      end
    return v[4];
  endfunction

  function automatic int pix_at(input int mode, input int x, input int y);
    case (mode)
      0:       return 100;
      1:       return (x == 10 && y == 10) ? 255 : 0;
      2:       return y;
      3:       return ((x + y) % 2 == 1) ? 200 : 50;
      default: return ((x * 73) ^ (y * 151) ^ (x * y * 17)) & 255;
    endcase
  endfunction

  // Model: per input sample, expected bus values derived from image positions.
  always @(posedge clk) begin
    int s;
    if (reset) begin
      m_resync = 1'b1; m_x = 0; m_y = 0; m_lvp = 1'b0;
      for (int k = 0; k < 8; k++) begin
        e_fv[k] = 0; e_lv[k] = 0; e_dv[k] = 0; e_chk[k] = 1; e_d[k] = 0; e_x[k] = -1; e_y[k] = 0;
      end
    end else begin
      s = n_edges % 8;
      if (m_resync) begin
        e_fv[s] = 0; e_lv[s] = 0; e_dv[s] = 0; e_chk[s] = 1; e_d[s] = 0; e_x[s] = -1; e_y[s] = 0;
      end else begin
        e_fv[s] = fv_in; e_lv[s] = lv_in; e_dv[s] = dv_in; e_chk[s] = dv_in;
        e_x[s] = m_x; e_y[s] = m_y; e_d[s] = 0;
        if (dv_in) begin
          if (m_x < HA) img[m_y][m_x] = int'(d_in);
          if (m_x < 2 || m_y < 2 || m_x >= HA) e_d[s] = border_val(int'(d_in));
          else e_d[s] = median9(m_y, m_x);
        end
      end
      if (!fv_in) m_resync = 1'b0;
      if (!lv_in) m_x = 0;
      else if (dv_in && m_x < W_MAX - 1) m_x++;
      if (!fv_in) m_y = 0;
      else if (m_lvp && !lv_in && m_y < R_MAX - 1) m_y++;
      m_lvp = lv_in;
    end
    n_edges++;
  end

  always @(negedge clk) begin
    int s;
    if (dv_o) dv_seen++;
    if (n_edges >= 4) begin
      s = (n_edges - 4) % 8;
      vectors++;
      if ({fv_o, lv_o, dv_o} !== {e_fv[s], e_lv[s], e_dv[s]}) begin
        miscompares++;
        $display("FAIL valids edge=%0d got fv/lv/dv=%b%b%b required %b%b%b",
                 n_edges, fv_o, lv_o, dv_o, e_fv[s], e_lv[s], e_dv[s]);
      end
      if (e_chk[s]) begin
        vectors++;
        if (d_o !== 8'(e_d[s])) begin
          miscompares++;
          $display("FAIL data x=%0d y=%0d got %0d required %0d", e_x[s], e_y[s], d_o, e_d[s]);
        end
        if (e_dv[s] && e_x[s] >= 0 && e_x[s] < W_MAX && e_y[s] < R_MAX)
          out_img[e_y[s]][e_x[s]] = int'(d_o);
      end
    end
  end

  task automatic check_lit(input string name, input int got, input int req);
    vectors++;
    if (got != req) begin
      miscompares++;
      $display("FAIL %s got %0d required %0d", name, got, req);
    end
  endtask

  task automatic cyc(input bit fv, input bit lv, input bit dv, input int d);
    @(negedge clk);
    fv_in = fv; lv_in = lv; dv_in = dv; d_in = 8'(d);
  endtask

  task automatic clear_out();
    for (int y = 0; y < R_MAX; y++)
      for (int x = 0; x < W_MAX; x++)
        out_img[y][x] = -1;
  endtask

  task automatic send_line(input int mode, input int w, input int y, input bit gap, input bit late);
    for (int x = 0; x < w; x++) begin
      if (late && x == w - 1) cyc(1, 0, 1, pix_at(mode, x, y));
      else cyc(1, 1, 1, pix_at(mode, x, y));
      if (gap && !(late && x == w - 1)) cyc(1, 1, 0, 0);
    end
    repeat (3) cyc(1, 0, 0, 0);
  endtask

  task automatic send_frame(input int mode, input int w, input int rows, input bit gap, input bit late);
    repeat (3) cyc(1, 0, 0, 0);
    for (int y = 0; y < rows; y++) send_line(mode, w, y, gap, late);
    repeat (4) cyc(0, 0, 0, 0);
  endtask

  initial begin
    int n255;
    reset = 1'b1;
    @(posedge clk); #1;
    check_lit("reset_state", int'({fv_o, lv_o, dv_o, d_o}), 0);
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    repeat (4) cyc(0, 0, 0, 0);

    clear_out();
    send_frame(0, HA, 5, 0, 0);
    check_lit("flat_interior", out_img[3][50], 100);
    check_lit("flat_last_col", out_img[4][701], 100);
    check_lit("flat_border", out_img[0][0], border_val(100));

    clear_out();
    send_frame(1, 32, 16, 0, 0);
    check_lit("impulse_11_11", out_img[11][11], 0);
    check_lit("impulse_10_10", out_img[10][10], 0);
    n255 = 0;
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 32; x++)
        if (out_img[y][x] == 255) n255++;
    check_lit("impulse_no_255", n255, 0);

    clear_out();
    send_frame(2, 20, 8, 0, 1);
    check_lit("ramp_5_5", out_img[5][5], 4);
    check_lit("ramp_7_2", out_img[2][7], 1);
    check_lit("ramp_row1_raw", out_img[1][5], border_val(1));
    check_lit("ramp_col1_raw", out_img[6][1], border_val(6));
    check_lit("ramp_late_pixel", out_img[5][19], 4);

    clear_out();
    send_frame(3, 24, 6, 1, 0);
    check_lit("gap_odd", out_img[4][7], 200);
    check_lit("gap_even", out_img[4][8], 50);

    clear_out();
    send_frame(4, W_MAX, 4, 0, 0);
    check_lit("overflow_705_0", out_img[0][705], border_val(9));
    check_lit("overflow_706_3", out_img[3][706], border_val(49));

    clear_out();
    repeat (3) cyc(1, 0, 0, 0);
    for (int y = 0; y < 3; y++) send_line(3, 40, y, 0, 0);
    for (int x = 0; x < 20; x++) cyc(1, 1, 1, pix_at(3, x, 3));
    @(negedge clk);
    check_lit("pre_reset_lv", int'(lv_o), 1);
    #2 reset = 1'b1;
    #1 check_lit("async_reset_outputs", int'({fv_o, lv_o, dv_o, d_o}), 0);
    @(negedge clk); reset = 1'b0;
    dv_seen = 0;
    for (int x = 20; x < 40; x++) cyc(1, 1, 1, pix_at(3, x, 3));
    repeat (3) cyc(1, 0, 0, 0);
    send_line(3, 40, 4, 0, 0);
    check_lit("resync_silent", dv_seen, 0);
    repeat (4) cyc(0, 0, 0, 0);
    clear_out();
    send_frame(3, 40, 5, 0, 0);
    check_lit("post_resync_4_7", out_img[4][7], 200);
    check_lit("post_resync_4_8", out_img[4][8], 50);

    repeat (8) cyc(0, 0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/median3x3_prefilter.md
# median3x3_prefilter

Streaming 3x3 median filter that sits directly upstream of the maze-tracking stage and removes salt-and-pepper noise from the 8-bit camera stream before binarization. It consumes the same frame/line/data-valid video bus that the tracker consumes and regenerates it unchanged, delayed by a fixed pipeline depth. The tracker therefore sees a cleaner image with identical framing.

## Interface
- H_ACTIVE, 702: maximum pixels per line; sizes both line buffers.
- DATA_W, 8: pixel width.
- clk  in  1  single clock; every register is clocked on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- video_frame_valid_in  in  1  high for the whole frame.
- video_line_valid_in  in  1  high for the whole line.
- video_data_valid_in  in  1  pixel strobe.
- video_data_in  in  DATA_W  raw pixel.
- video_frame_valid  out  1  frame_valid_in delayed by 4 cycles.
- video_line_valid  out  1  line_valid_in delayed by 4 cycles.
- video_data_valid  out  1  data_valid_in delayed by 4 cycles.
- video_data_out  out  DATA_W  filtered pixel.

## Operation
- col counter (10 bit):
  - Clears while line_valid_in is low.
  - Increments on each data_valid_in.
  - Saturates at H_ACTIVE.
- row counter (2 bit):
  - Clears while frame_valid_in is low.
  - Increments on each falling edge of line_valid_in.
  - Saturates at 2.
- Line buffers lb0 and lb1, each H_ACTIVE x DATA_W. On data_valid_in with col < H_ACTIVE:
  - lb0[col] <= pixel.
  - lb1[col] <= old lb0[col].
  - Read and write occur in the same cycle; the read returns the old contents.
- Window: a 3x3 register array. On data_valid_in it shifts one column and loads the new column {lb1[col], lb0[col], pixel}. It holds its contents when data_valid_in is low.
- The output for input position (x,y) is the median of rows y-2..y and columns x-2..x. The image is therefore shifted by one pixel down and one pixel right, which is intentional.
- Median network, unsigned compare:
  - Stage 2: sort each row (min/med/max).
  - Stage 3: compute max of the mins, med of the meds, and min of the maxes.
  - Stage 4: output the median of those three.
- Border rule: when x<2, y<2, or col==H_ACTIVE (overflow pixels), the output is the raw input pixel delayed through the same pipeline.
- Resync flag:
  - Set by reset.
  - Cleared on the first cycle in which frame_valid_in is low.
  - While the flag is set, all valid outputs are forced to 0 and the line buffers are not written. This prevents a partial frame from being emitted after a reset.

## Timing
- Latency is exactly 4 clocks from a data_valid_in sample to the matching video_data_valid and video_data_out. The line_valid and frame_valid outputs use the same 4-clock shift.
- The valid pipeline is free-running: it advances every clock regardless of data_valid_in. Gaps inside a line are preserved cycle for cycle.
- Throughput: one pixel per clock sustained. No backpressure.
- Reset values:
  - All outputs 0.
  - Counters 0.
  - Window 0.
  - Resync flag set.
- Line buffer contents are not reset. Stale data cannot reach the output because of the y<2 border rule.
- Simultaneous falling edge of line_valid_in with a data_valid_in: the pixel is processed with the old row value, and the row increments afterwards.
- Reset asserted mid-line: outputs drop to 0 asynchronously. After release, output stays silent until frame_valid_in has gone low once.

## Configuration
- MEDIAN_BORDER_ZERO_EN:
  - Defined: border-rule pixels output 0.
  - Undefined (default): border-rule pixels output the raw delayed pixel.
  - Validity timing is identical in both builds.

## Test plan
- Flat frame (all pixels 100, 702x288) -> every output pixel is 100; valid outputs equal the inputs delayed by 4 cycles.
- Single pixel 255 at (10,10) on a background of 0 -> no output pixel is ever 255; output at (11,11) is 0.
- Vertical ramp where pixel = row, rows >= 2 -> output equals row-1 for x>=2; rows 0 and 1 pass the raw value (0 when MEDIAN_BORDER_ZERO_EN is defined).
- data_valid_in gapped 1-on/1-off within a line -> output valid pattern is identical shifted by 4 cycles; pixel values match the contiguous-stream result.
- Line of 710 pixels -> pixels 702..709 pass raw; the line buffers are unchanged at column 701.
- Reset pulse mid-frame at row 100 -> all outputs are 0 until the next frame_valid_in low; the next full frame is filtered normally.
